// File: rtl/multiplier_datapath_taint_track_1bit_pkg.sv
// Shared constants for the taint-tracked shift-add multiplier (control FSM + datapath).
// Width-dependent sizes are exposed as functions so both blocks derive them from one place.
package mult_pkg;
  localparam int DEF_WIDTH  = 1024;
  localparam int RS_WIDTH   = 2*DEF_WIDTH + 1;
  localparam int PROD_WIDTH = 2*DEF_WIDTH;

  localparam logic [11:0] START = 12'd0;
  localparam logic [11:0] INIT  = 12'd1;
  localparam logic [11:0] FINAL = 12'(2*(DEF_WIDTH + 1));

  function automatic int rs_width(input int w);
    return 2*w + 1;
  endfunction

  function automatic int prod_width(input int w);
    return 2*w;
  endfunction

  function automatic int final_state(input int w);
    return 2*(w + 1);
  endfunction
endpackage

// File: rtl/multiplier_datapath_taint_track_1bit_taint_ld_reg.sv
// Load-enabled register with a sticky one-bit data taint; a tainted enable
// taints the contents whether or not the load actually happens.
module taint_ld_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic         ld_t,
  input  logic [W-1:0] d,
  input  logic         d_t,
  output logic [W-1:0] q,
  output logic         q_t
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      q_t <= 1'b0;
    end else begin
      if (ld) q <= d;
      q_t <= (ld ? d_t : q_t) | ld_t;
    end
  end
endmodule

// File: rtl/multiplier_datapath_taint_track_1bit.sv
// Datapath of the shift-add multiplier: operand registers, running sum with carry,
// product capture, and conservative one-bit taint tracking alongside each.
module multiplier_datapath_taint_track_1bit
  import mult_pkg::*;
#(
  parameter int WIDTH = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 multiplicand_t,
  input  logic                 multiplier_t,
  input  logic                 rsload,
  input  logic                 rsclear,
  input  logic                 rsshr,
  input  logic                 mrld,
  input  logic                 mdld,
  input  logic                 productDone,
  input  logic                 rsload_t,
  input  logic                 rsclear_t,
  input  logic                 rsshr_t,
  input  logic                 mrld_t,
  input  logic                 mdld_t,
  input  logic                 productDone_t,
  output logic [WIDTH-1:0]     multiplierReg,
  output logic                 multiplierReg_t,
  output logic [2*WIDTH-1:0]   product,
  output logic                 product_t,
  output logic                 product_valid,
  output logic                 product_valid_t
);
  localparam int RW = rs_width(WIDTH);
  localparam int PW = prod_width(WIDTH);

  logic [WIDTH-1:0] md_reg;
  logic             md_t;
  logic [RW-1:0]    rs, rs_nxt;
  logic             rs_t, rs_t_nxt;

  taint_ld_reg #(.W(WIDTH)) u_md (
    .clk(clk), .rst_n(rst_n), .ld(mdld), .ld_t(mdld_t),
    .d(multiplicand), .d_t(multiplicand_t), .q(md_reg), .q_t(md_t)
  );

  taint_ld_reg #(.W(WIDTH)) u_mr (
    .clk(clk), .rst_n(rst_n), .ld(mrld), .ld_t(mrld_t),
    .d(multiplier), .d_t(multiplier_t), .q(multiplierReg), .q_t(multiplierReg_t)
  );

  // Upper half plus carry bit accumulates; the add is W+1 bits wide so the carry survives.
  always_comb begin
    rs_nxt = rs;
    if (rsclear)     rs_nxt = '0;
    else if (rsload) rs_nxt = {rs[RW-1:WIDTH] + {1'b0, md_reg}, rs[WIDTH-1:0]};
    else if (rsshr)  rs_nxt = rs >> 1;
  end

  // Clear scrubs data taint but a tainted clear strobe still taints the sum.
  always_comb begin
    rs_t_nxt = rs_t | (rsload & md_t) | rsload_t | rsshr_t | rsclear_t;
    if (rsclear) rs_t_nxt = rsclear_t;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs              <= '0;
      rs_t            <= 1'b0;
      product         <= '0;
      product_t       <= 1'b0;
      product_valid   <= 1'b0;
      product_valid_t <= 1'b0;
    end else begin
      rs              <= rs_nxt;
      rs_t            <= rs_t_nxt;
      product_valid   <= productDone;
      product_valid_t <= productDone_t;
      if (productDone) begin
        product   <= rs_nxt[PW-1:0];
        product_t <= rs_t_nxt | productDone_t;
      end
    end
  end
endmodule

// File: tb/tb_multiplier_datapath_taint_track_1bit.sv
// Self-checking bench: the bench plays the control FSM and compares against plain
// multiplication and a per-run taint summary.
module tb_multiplier_datapath_taint_track_1bit;
  localparam int W  = 4;
  localparam int PW = 2*W;

  logic clk = 1'b0;
  logic rst_n;
  logic [W-1:0] multiplicand, multiplier;
  logic multiplicand_t, multiplier_t;
  logic rsload, rsclear, rsshr, mrld, mdld, productDone;
  logic rsload_t, rsclear_t, rsshr_t, mrld_t, mdld_t, productDone_t;
  logic [W-1:0]  multiplierReg;
  logic          multiplierReg_t;
  logic [PW-1:0] product;
  logic          product_t, product_valid, product_valid_t;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multiplier_datapath_taint_track_1bit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .multiplicand_t(multiplicand_t), .multiplier_t(multiplier_t),
    .rsload(rsload), .rsclear(rsclear), .rsshr(rsshr),
    .mrld(mrld), .mdld(mdld), .productDone(productDone),
    .rsload_t(rsload_t), .rsclear_t(rsclear_t), .rsshr_t(rsshr_t),
    .mrld_t(mrld_t), .mdld_t(mdld_t), .productDone_t(productDone_t),
    .multiplierReg(multiplierReg), .multiplierReg_t(multiplierReg_t),
    .product(product), .product_t(product_t),
    .product_valid(product_valid), .product_valid_t(product_valid_t)
  );

  task automatic idle();
    rsload = 0; rsclear = 0; rsshr = 0; mrld = 0; mdld = 0; productDone = 0;
    rsload_t = 0; rsclear_t = 0; rsshr_t = 0; mrld_t = 0; mdld_t = 0; productDone_t = 0;
    multiplicand_t = 0; multiplier_t = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Acts as the control FSM for one multiply; reports what it observed.
  // inj_shr: sequence cycle index at which rsshr_t is raised (-1 = never).
  task automatic run_mult(input logic [W-1:0] md, input logic [W-1:0] mr,
                          input logic mdt, input logic mrt, input int inj_shr, input logic pd_t,
                          output logic [PW-1:0] g_prod, output logic g_pt, output logic g_vt,
                          output int g_lat, output int g_pulses, output logic g_stable,
                          output logic [W-1:0] g_mrreg, output logic g_mrt);
    int ops[$];
    logic [PW-1:0] prev;
    ops.push_back(0);
    ops.push_back(1);
    for (int k = 0; k < W; k++) begin
      if (mr[k]) ops.push_back(2);
      ops.push_back(1);
    end
    prev = product; g_stable = 1; g_lat = -1; g_pulses = 0;
    g_prod = '0; g_pt = 0; g_vt = 0; g_mrreg = '0; g_mrt = 0;
    for (int i = 0; i < ops.size() + 12; i++) begin
      idle();
      if (i < ops.size()) begin
        case (ops[i])
          0: begin
            mdld = 1; mrld = 1; rsclear = 1;
            multiplicand = md; multiplier = mr; multiplicand_t = mdt; multiplier_t = mrt;
          end
          1: rsshr = 1;
          default: rsload = 1;
        endcase
      end
      if (i == ops.size() - 1) begin productDone = 1; productDone_t = pd_t; end
      if (i == inj_shr) rsshr_t = 1;
      step();
      if (i == 0) begin g_mrreg = multiplierReg; g_mrt = multiplierReg_t; end
      if (product_valid) begin
        g_pulses++;
        if (g_lat < 0) begin
          g_lat = i + 1; g_prod = product; g_pt = product_t; g_vt = product_valid_t;
        end
      end else if (g_lat < 0 && product !== prev) g_stable = 0;
    end
    idle();
  endtask

  task automatic test_reset();
    idle(); multiplicand = '0; multiplier = '0;
    rst_n = 0;
    #12;
    checks++; if (product !== '0) begin failures++; $display("FAIL reset_product got=%h exp=0", product); end
    checks++; if ({product_t, product_valid, product_valid_t} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {product_t, product_valid, product_valid_t}); end
    checks++; if ({multiplierReg, multiplierReg_t} !== '0) begin
      failures++; $display("FAIL reset_mrreg got=%h/%b exp=0/0", multiplierReg, multiplierReg_t); end
    @(negedge clk); rst_n = 1;
    step();
  endtask

  // Checks one run against arithmetic product, expected latency and expected taints.
  task automatic check_run(input string nm, input logic [W-1:0] md, input logic [W-1:0] mr,
                           input logic mdt, input logic mrt, input int inj, input logic pdt,
                           input logic exp_pt);
    logic [PW-1:0] gp; logic gpt, gvt, gst, gmt; int glat, gpul; logic [W-1:0] gmr;
    logic [PW-1:0] exp_p;
    int exp_lat;
    exp_p   = PW'(md) * PW'(mr);
    exp_lat = W + 2 + $countones(mr);
    run_mult(md, mr, mdt, mrt, inj, pdt, gp, gpt, gvt, glat, gpul, gst, gmr, gmt);
    checks++; if (glat !== exp_lat) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", nm, glat, exp_lat); end
    checks++; if (gp !== exp_p) begin failures++; $display("FAIL %s_product got=%h exp=%h", nm, gp, exp_p); end
    checks++; if (gpt !== exp_pt) begin failures++; $display("FAIL %s_product_t got=%b exp=%b", nm, gpt, exp_pt); end
    checks++; if (gvt !== pdt) begin failures++; $display("FAIL %s_valid_t got=%b exp=%b", nm, gvt, pdt); end
    checks++; if (gpul !== 1) begin failures++; $display("FAIL %s_pulses got=%0d exp=1", nm, gpul); end
    checks++; if (gst !== 1'b1) begin failures++; $display("FAIL %s_stable got=%b exp=1", nm, gst); end
    checks++; if ({gmr, gmt} !== {mr, mrt}) begin
      failures++; $display("FAIL %s_mrreg got=%h/%b exp=%h/%b", nm, gmr, gmt, mr, mrt); end
  endtask

  task automatic test_directed();
    check_run("d13x11", 4'd13, 4'd11, 0, 0, -1, 0, 0);
    check_run("dFxF",   4'hF,  4'hF,  0, 0, -1, 0, 0);
    check_run("d9x0",   4'd9,  4'd0,  0, 0, -1, 0, 0);
  endtask

  task automatic test_taint();
    check_run("md_t_mr0", 4'd7, 4'd0, 1, 0, -1, 0, 0);
    check_run("md_t_mr1", 4'd7, 4'd1, 1, 0, -1, 0, 1);
    check_run("mr_t_only", 4'd5, 4'd6, 0, 1, -1, 0, 0);
    check_run("clean_after", 4'd5, 4'd6, 0, 0, -1, 0, 0);
  endtask

  task automatic test_strobe_taint();
    check_run("shr_t", 4'd13, 4'd11, 0, 0, 3, 0, 1);
    check_run("pd_t",  4'd3,  4'd5,  0, 0, -1, 1, 1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 10; n++) begin
      logic [W-1:0] md, mr; logic mdt, mrt;
      md = W'($urandom); mr = W'($urandom);
      mdt = 1'($urandom); mrt = 1'($urandom);
      check_run("rand", md, mr, mdt, mrt, -1, 0, mdt && (mr != 0));
    end
  endtask

  task automatic test_reset_mid();
    idle();
    mdld = 1; mrld = 1; rsclear = 1; multiplicand = 4'd11; multiplier = 4'd7;
    step(); idle(); rsshr = 1;
    step(); idle(); rsload = 1;
    step(); idle(); rsshr = 1;
    #2 rst_n = 0;
    #1;
    checks++; if ({product, product_t, product_valid, product_valid_t} !== '0) begin
      failures++; $display("FAIL midrst_outputs got=%h/%b%b%b exp=0", product, product_t, product_valid, product_valid_t); end
    checks++; if ({multiplierReg, multiplierReg_t} !== '0) begin
      failures++; $display("FAIL midrst_mrreg got=%h/%b exp=0", multiplierReg, multiplierReg_t); end
    idle();
    @(negedge clk); rst_n = 1;
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (product_valid || product !== '0) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_quiet got=%0d exp=0", seen); end
    end
    check_run("post_rst", 4'd11, 4'd7, 0, 0, -1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_taint();
    test_strobe_taint();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multiplier_datapath_taint_track_1bit.md
# multiplier_datapath_taint_track_1bit

Datapath half of the taint-tracked sequential shift-add multiplier. It sits directly downstream of the multiplier control FSM and executes that FSM's register strobes. It holds the multiplicand, multiplier and running-sum registers, and returns `multiplierReg` / `multiplierReg_t` to the FSM for bit tests. It also captures and presents the finished 2·WIDTH-bit product with a one-bit conservative taint.

## Interface
- `WIDTH`, default 1024: operand width in bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `multiplicand`, `multiplier`  in  WIDTH  operands from upstream; sampled on `mdld` and `mrld` respectively.
- `multiplicand_t`, `multiplier_t`  in  1  operand taints.
- `rsload`, `rsclear`, `rsshr`, `mrld`, `mdld`, `productDone`  in  1  control strobes from the FSM.
- `rsload_t`, `rsclear_t`, `rsshr_t`, `mrld_t`, `mdld_t`, `productDone_t`  in  1  strobe taints.
- `multiplierReg`  out  WIDTH  multiplier register, to the FSM.
- `multiplierReg_t`  out  1  multiplier register taint.
- `product`  out  2·WIDTH  captured product; holds until the next capture.
- `product_t`  out  1  product taint.
- `product_valid`  out  1  one-cycle pulse when `product` updates.
- `product_valid_t`  out  1  taint of `product_valid`.

## Operation
- Registers:
  - `mdReg` [WIDTH]
  - `mrReg` [WIDTH]
  - `rs` [2·WIDTH+1]: the extra MSB holds the add carry.
  - Taint bits `md_t`, `mr_t`, `rs_t`.
  - Output registers as listed under Interface.
- `mdld`: `mdReg` ← `multiplicand`. `mrld`: `mrReg` ← `multiplier`. `mrReg` is never shifted; the FSM indexes its bits directly.
- `rs` update priority, highest first; lower strobes are ignored in that cycle:
  - `rsclear`: `rs` ← 0.
  - `rsload`: `rs[2W:W]` ← `rs[2W:W]` + `mdReg`. This is a W+1-bit result; the low half is unchanged.
  - `rsshr`: `rs` ← `rs` >> 1, with 0 shifted into the MSB.
- Sequence expected from the FSM: clear, then shift, optional add, shift, …, and a final shift in the cycle carrying `productDone`. Bit k's add is followed by exactly WIDTH−k shifts, so the finished value is `rs[2W-1:0]` = multiplicand × multiplier. The datapath does not check the sequence.
- Capture: while `productDone` = 1, `product` ← the post-shift value of `rs[2W-1:0]`, i.e. the same-edge next value. `product_valid` goes to 1 for exactly that next cycle.
- Taint rules. All are sticky ORs, applied every cycle in which an enable's taint is 1, whether or not the enable itself is asserted (a conservative rule).
  - `md_t` ← (`mdld` ? `multiplicand_t` : `md_t`) | `mdld_t`.
  - `mr_t` ← (`mrld` ? `multiplier_t` : `mr_t`) | `mrld_t`.
  - On `rsclear`: `rs_t` ← `rsclear_t`. Clear drops data taint only.
  - Otherwise: `rs_t` ← `rs_t` | (`rsload` & `md_t`) | `rsload_t` | `rsshr_t` | `rsclear_t`.
  - On capture: `product_t` ← next `rs_t` | `productDone_t`. Otherwise `product_t` holds.
  - `product_valid_t` ← `productDone_t`, registered alongside `product_valid`.
- Simultaneous `mdld` and `rsload`: the add uses the old `mdReg`.

## Timing
- Reset (`rst_n` low, asynchronous) clears all data registers, all taint bits, `product`, `product_t`, `product_valid` and `product_valid_t` to 0.
- Reset mid-operation abandons the multiply: no `product_valid`, and `product` reads 0.
- All outputs are registered; nothing is combinational from input to output.
- `multiplierReg` reflects `mrld` one cycle after the strobe, which is in time for the FSM's first bit test at INIT+1.
- Latency: with INIT (`mdld`, `mrld`, `rsclear`) in cycle c and p ones in `multiplier`, FINAL is cycle c+1+WIDTH+p and `product_valid` is high in cycle c+2+WIDTH+p.
- Back-to-back multiplies: `product` stays stable while the next operation runs.

## Structure
- Shared package `mult_pkg` holds:
  - `RS_WIDTH` = 2·WIDTH+1 and `PROD_WIDTH` = 2·WIDTH.
  - The FSM state constants START=0, INIT=1, FINAL=2·(WIDTH+1), so the control FSM and this block agree.
- One sub-module: `taint_ld_reg`, a parameterised-width register with load enable, a data taint and an enable taint, implementing the sticky rule above. It is instantiated for `mdReg` and `mrReg`.
- `rs` and the capture logic stay in the top module.

## Test plan
- WIDTH=4, md=4'd13, mr=4'd11, drive the FSM sequence → `product_valid` high at c+2+4+3 = c+9, `product`=8'd143, `product_t`=0.
- WIDTH=4, md=4'hF, mr=4'hF → carry exercised, `product`=8'hE1 (225).
- WIDTH=4, mr=0, md=4'd9 → no `rsload`, `product_valid` at c+6, `product`=0.
- Taint: `multiplicand_t`=1 at INIT, mr=4'd0 → `product_t`=0. Repeat with mr=4'd1 → `product_t`=1.
- Tainted strobe: `rsshr_t`=1 for one mid-sequence cycle, all operands clean → `product_t`=1. `product` value is unchanged from the clean run.
- Mid-multiply `rst_n` pulse → all outputs 0 immediately. No `product_valid` until a fresh INIT. The next run produces a correct product with clean taint.
